// File: rtl/fir_audio_i2s_out.sv
// +----------------------------------------------------------------------------+
// | Module      : fir_audio_i2s_out                                            |
// | Description : Audio output stage for the FIR filter. Captures each filter  |
// |               word on rdy, rounds (half-up), shifts and saturates it to a  |
// |               signed OUT_W-bit sample, buffers samples in a small FIFO and |
// |               serialises them as mono-duplicated I2S stereo frames.        |
// | Ports       : clk        - system clock, rising edge                       |
// |               sclr       - asynchronous active-high reset                  |
// |               rdy, din   - filter output strobe and word                   |
// |               i2s_bclk   - DAC bit clock                                   |
// |               i2s_lrck   - word clock, 0 = left, 1 = right                 |
// |               i2s_sdata  - serial data, MSB first, one bclk after lrck     |
// |               fifo_level - FIFO occupancy 0..2^FIFO_AW                     |
// |               overflow   - sticky, a sample was dropped on a full FIFO     |
// |               underrun   - sticky, a frame started empty after playback   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fir_audio_i2s_out #(
    parameter int DIN_W    = 36,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 17,
    parameter int FIFO_AW  = 3,
    parameter int BCLK_DIV = 2
) (
    input  logic               clk,
    input  logic               sclr,
    input  logic               rdy,
    input  logic [DIN_W-1:0]   din,
    output logic               i2s_bclk,
    output logic               i2s_lrck,
    output logic               i2s_sdata,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic               underrun
);

    localparam int RW    = DIN_W + 1;
    localparam int SR_W  = 2 * OUT_W;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [DIV_W-1:0]     c_DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic signed [RW-1:0] c_HALF     = RW'(1) << (SHIFT - 1);
    localparam logic signed [RW-1:0] c_SMAX     = RW'((2 ** (OUT_W - 1)) - 1);
    // Bitwise inverse of 2^(OUT_W-1)-1 is -2^(OUT_W-1) in two's complement
    localparam logic signed [RW-1:0] c_SMIN     = ~c_SMAX;
    localparam logic [OUT_W-1:0]     c_OMAX     = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]     c_OMIN     = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [4:0]           c_CNT_LAST = 5'd31;

    // ------------------------------------------------------------------
    // Sample conversion pipeline: round on the rdy edge, saturate on the
    // next edge, FIFO write on the edge after that.
    // ------------------------------------------------------------------
    logic signed [RW-1:0] r_round;
    logic                 r_v1;
    logic [OUT_W-1:0]     r_sample;
    logic                 r_v2;
    logic signed [RW-1:0] w_shr;
    logic [OUT_W-1:0]     w_sat;

    assign w_shr = r_round >>> SHIFT;

    always_comb begin
        w_sat = w_shr[OUT_W-1:0];
        if (w_shr > c_SMAX) begin
            w_sat = c_OMAX;
        end else if (w_shr < c_SMIN) begin
            w_sat = c_OMIN;
        end
    end

    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            r_round  <= '0;
            r_v1     <= 1'b0;
            r_sample <= '0;
            r_v2     <= 1'b0;
        end else begin
            r_v1 <= rdy;
            if (rdy) begin
                // Sign-extend by one bit so adding the half LSB cannot wrap
                r_round <= $signed({din[DIN_W-1], din}) + c_HALF;
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sample <= w_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bit clock divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic             r_bclk;
    logic             w_div_end;
    logic             w_fall;

    assign w_div_end = (r_div == c_DIV_LAST);
    assign w_fall    = w_div_end & r_bclk;

    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_div_end) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sample FIFO. Pointers carry one extra wrap bit to tell full from
    // empty.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] r_mem [DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [OUT_W-1:0] w_rd_data;

    logic [4:0]       r_bit_cnt;
    logic [4:0]       w_cnt_next;
    logic             w_frame_start;

    assign w_cnt_next    = r_bit_cnt + 5'd1;
    assign w_frame_start = w_fall && (r_bit_cnt == c_CNT_LAST);

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                       (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    // Emptiness is judged before this edge's write: no write-to-pop bypass
    assign w_pop     = w_frame_start && !w_empty;
    // A full FIFO still accepts the write when the same edge pops a slot
    assign w_push    = r_v2 && (!w_full || w_pop);
    assign w_rd_data = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= r_sample;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencing, serialiser and status flags
    // ------------------------------------------------------------------
    logic [SR_W-1:0] r_sr;
    logic            r_lrck;
    logic            r_sdata;
    logic            r_played;
    logic            r_overflow;
    logic            r_underrun;

    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_bit_cnt  <= '0;
            r_sr       <= '0;
            r_lrck     <= 1'b0;
            r_sdata    <= 1'b0;
            r_played   <= 1'b0;
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (FIFO_AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (FIFO_AW+1)'(1);
            end
            if (r_v2 && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end

            if (w_fall) begin
                r_bit_cnt <= w_cnt_next;
                r_lrck    <= w_cnt_next[4];
                // Outgoing MSB leaves before the load, which yields the
                // one-bclk lag between lrck and the word MSB.
                r_sdata   <= r_sr[SR_W-1];
                if (w_frame_start) begin
                    if (w_pop) begin
                        r_sr     <= {w_rd_data, w_rd_data};
                        r_played <= 1'b1;
                    end else begin
                        r_sr <= '0;
                        if (r_played) begin
                            r_underrun <= 1'b1;
                        end
                    end
                end else begin
                    r_sr <= {r_sr[SR_W-2:0], 1'b0};
                end
            end
        end
    end

    assign i2s_bclk   = r_bclk;
    assign i2s_lrck   = r_lrck;
    assign i2s_sdata  = r_sdata;
    assign fifo_level = r_wr_ptr - r_rd_ptr;
    assign overflow   = r_overflow;
    assign underrun   = r_underrun;

endmodule

`default_nettype wire
